gpio_int_multi: RTL and testbench
=================================

Name: gpio_int_multi

Overview:
Parametrised next-generation GPIO port with interrupts, for memory-mapped peripheral blocks on the processor bus. Provides W bidirectional pins with per-pin direction, atomic set/clear of outputs, a glitch filter sampled on a divided tick, and per-pin edge selection (rising, falling or both). Adds an interrupt-enable mask, write-1-to-clear status and a single aggregate interrupt output to the interrupt controller.

Parameters:
W, 16, number of pins; 1..32
DIV, 128, sample-tick period in Clk cycles; 1..65536; DIV=1 means a tick every cycle
FILT_LEN, 2, consecutive agreeing tick samples needed to change filtered state; 2..8

Ports:
Clk  in  1  clock
Reset  in  1  reset: synchronous, active-high (Reset, synchronous, active-high; clock Clk)
Addr  in  3  register select
DataRd  out  W  read data, combinational
DataWr  in  W  write data
En  in  1  block select
Rd  in  1  read strobe; informational only, reads have no side effects
Wr  in  1  write strobe; a write occurs on a Clk edge with En&Wr=1
Port  inout  W  pins; bit i is driven with OutReg[i] when DirReg[i]=1, else high-Z
IntStatus  out  W  latched interrupt status
IntClr  in  W  hardware clear of IntStatus bits, level, one bit per pin
Irq  out  1  registered OR of (IntStatus & IntEnReg)

Behaviour:
- Register map (Addr: write / read):
  0 DATA: OutReg<=DataWr / synchronised pin value Sync1
  1 DIR: DirReg / DirReg
  2 SET: OutReg<=OutReg|DataWr / OutReg
  3 CLR: OutReg<=OutReg&~DataWr / OutReg
  4 EDGE: EdgeReg, 0=rising 1=falling / EdgeReg
  5 BOTH: BothReg, 1=both edges, overrides EDGE / BothReg
  6 INTEN: IntEnReg / IntEnReg
  7 STAT: write-1-to-clear IntStatus / IntStatus
- DataRd=0 when En=0.
- Reset values: OutReg, DirReg, EdgeReg, BothReg, IntEnReg, IntStatus, Irq, Sync0/1, sample shift registers, Filt, FiltPrev, divider and prime counter all 0. All pins are high-Z.
- Synchroniser: Sync0<=Port and Sync1<=Sync0 on every Clk.
- Divider:
  - Counts 0..DIV-1 and wraps to 0.
  - Tick=1 in the cycle where count==DIV-1.
- Filter, per pin:
  - On Tick, Samp<={Samp[FILT_LEN-2:0],Sync1}.
  - On the following Clk, if Samp is all 1s then Filt<=1; if all 0s then Filt<=0; otherwise Filt holds.
- Priming:
  - The prime counter counts ticks up to FILT_LEN, then saturates and sets Armed=1.
  - While Armed=0, FiltPrev<=Filt and edge events are forced to 0, so pin levels present at reset produce no interrupt.
- Edges:
  - Rise=Filt&~FiltPrev and Fall=~Filt&FiltPrev, with FiltPrev<=Filt every Clk.
  - Ev = Armed & (BothReg ? Rise|Fall : EdgeReg ? Fall : Rise).
- Status:
  - IntStatus <= (IntStatus & ~Clr) | Ev.
  - Clr = IntClr | (DataWr when En&Wr&Addr==7).
  - Set wins over a simultaneous clear.
- Irq: updated one Clk after IntStatus or IntEnReg changes.
- Latency: pin change to IntStatus set is at most 2 + FILT_LEN*DIV + 3 Clk cycles.
- Glitch rejection: a pulse shorter than (FILT_LEN-1)*DIV cycles is never reported. Pulses between that and FILT_LEN*DIV cycles may be reported, depending on tick alignment.
- Output mode: an output pin still feeds the filter, so it can raise its own interrupt.
- Reset asserted mid-operation: all state returns to reset values the next edge and priming restarts.
- Changing EDGE/BOTH/INTEN never sets or clears status by itself.

Decomposition:
- Package gpio_int_pkg: address constants GPIO_DATA..GPIO_STAT (3-bit), edge encoding constants.
- Sub-module gpio_pin_filter: one pin's Sync0/1, Samp, Filt, FiltPrev and Rise/Fall outputs.
  - Inputs: Tick, Armed.
  - Instantiated W times by a generate loop.
  - Divider, prime counter and registers stay in the top level.

Test Plan:
- Bench config W=16, DIV=4, FILT_LEN=2.
- Reset: Port pulled 16'hA5A5 externally, wait 40 cycles -> IntStatus=0, Irq=0, DATA read =16'hA5A5, all pins Z.
- Output: write DIR=16'h00FF, DATA=16'h0F0F, SET=16'h0030, CLR=16'h0001 -> Port[7:0]=8'h3E, Port[15:8] Z, read Addr 2 =16'h0F3E.
- Edges: INTEN=FFFF, EDGE=0002, BOTH=0004; toggle pins 0,1,2 low->high->low (each level held 20 cycles) -> status bit0 set on rise, bit1 set on fall, bit2 set on both; Irq=1 within 16 cycles of each edge.
- Glitch: 3-cycle high pulse on pin 3 -> IntStatus[3]=0; 12-cycle pulse -> IntStatus[3]=1.
- Clear/mask: write STAT=0001 -> bit0 cleared, others kept; IntClr=0002 for one cycle -> bit1 cleared; INTEN=0 -> Irq=0 next cycle with IntStatus unchanged; clear coincident with a new edge -> bit stays 1.
- Reset mid-operation: Reset pulsed while status=FFFF and DIR=FFFF -> next cycle all registers 0; no status within priming window despite high pins.

Source files
------------

// File: rtl/gpio_int_pkg.sv
// Shared constants for the interrupting GPIO port: register addresses and
// edge-select encodings.
package gpio_int_pkg;

   localparam logic [2:0] GPIO_DATA  = 3'd0;
   localparam logic [2:0] GPIO_DIR   = 3'd1;
   localparam logic [2:0] GPIO_SET   = 3'd2;
   localparam logic [2:0] GPIO_CLR   = 3'd3;
   localparam logic [2:0] GPIO_EDGE  = 3'd4;
   localparam logic [2:0] GPIO_BOTH  = 3'd5;
   localparam logic [2:0] GPIO_INTEN = 3'd6;
   localparam logic [2:0] GPIO_STAT  = 3'd7;

   localparam logic EDGE_RISE  = 1'b0;
   localparam logic EDGE_FALL  = 1'b1;
   localparam logic BOTH_EDGES = 1'b1;

endpackage

// File: rtl/gpio_pin_filter.sv
// One pin's synchroniser, tick-sampled glitch filter and edge detector.
// Edge outputs are already gated by the shared priming flag.
module gpio_pin_filter #(
   parameter int FILT_LEN = 2
) (
   input  logic Clk,
   input  logic Reset,
   input  logic pin_i,
   input  logic tick_i,
   input  logic armed_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic                sync0_q, sync0_d;
   logic                sync1_q, sync1_d;
   logic [FILT_LEN-1:0] samp_q, samp_d;
   logic                filt_q, filt_d;
   logic                filt_prev_q, filt_prev_d;

   always_comb begin
      sync0_d     = pin_i;
      sync1_d     = sync0_q;
      samp_d      = samp_q;
      filt_d      = filt_q;
      filt_prev_d = filt_q;
      if (tick_i) samp_d = {samp_q[FILT_LEN-2:0], sync1_q};
      // The filtered level only moves when every sample in the window agrees.
      if (&samp_q)       filt_d = 1'b1;
      else if (~|samp_q) filt_d = 1'b0;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync0_q     <= 1'b0;
         sync1_q     <= 1'b0;
         samp_q      <= '0;
         filt_q      <= 1'b0;
         filt_prev_q <= 1'b0;
      end else begin
         sync0_q     <= sync0_d;
         sync1_q     <= sync1_d;
         samp_q      <= samp_d;
         filt_q      <= filt_d;
         filt_prev_q <= filt_prev_d;
      end
   end

   assign sync_o = sync1_q;
   assign rise_o = armed_i &  filt_q & ~filt_prev_q;
   assign fall_o = armed_i & ~filt_q &  filt_prev_q;

endmodule

// File: rtl/gpio_int_multi.sv
// W-pin GPIO port with direction, set/clear, filtered edge interrupts,
// write-1-to-clear status and an aggregate registered interrupt.
module gpio_int_multi
   import gpio_int_pkg::*;
#(
   parameter int W        = 16,
   parameter int DIV      = 128,
   parameter int FILT_LEN = 2
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic [2:0]   Addr,
   output logic [W-1:0] DataRd,
   input  logic [W-1:0] DataWr,
   input  logic         En,
   input  logic         Rd,
   input  logic         Wr,
   inout  wire  [W-1:0] Port,
   output logic [W-1:0] IntStatus,
   input  logic [W-1:0] IntClr,
   output logic         Irq
);

   localparam int             CW         = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]  DIV_LAST   = CW'(DIV - 1);
   localparam int             PW         = $clog2(FILT_LEN + 1);
   localparam logic [PW-1:0]  PRIME_FULL = PW'(FILT_LEN);

   logic [CW-1:0] div_q, div_d;
   logic [PW-1:0] prime_q, prime_d;
   logic          settle_q, settle_d;
   logic          armed_q, armed_d;
   logic [W-1:0]  out_q, out_d, dir_q, dir_d, edge_q, edge_d;
   logic [W-1:0]  both_q, both_d, inten_q, inten_d, stat_q, stat_d;
   logic          irq_q, irq_d;
   logic [W-1:0]  sync, rise, fall, ev, clr;
   logic          tick, we;
   logic          rd_unused;

   assign rd_unused = Rd;
   assign tick      = (div_q == DIV_LAST);
   assign we        = En & Wr;

   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_pin
         gpio_pin_filter #(.FILT_LEN(FILT_LEN)) u_filt (
            .Clk     (Clk),
            .Reset   (Reset),
            .pin_i   (Port[gi]),
            .tick_i  (tick),
            .armed_i (armed_q),
            .sync_o  (sync[gi]),
            .rise_o  (rise[gi]),
            .fall_o  (fall[gi])
         );
         assign Port[gi] = dir_q[gi] ? out_q[gi] : 1'bz;
         assign ev[gi]   = (both_q[gi] == BOTH_EDGES) ? (rise[gi] | fall[gi]) :
                           (edge_q[gi] == EDGE_FALL)  ? fall[gi] : rise[gi];
      end
   endgenerate

   always_comb begin
      div_d   = tick ? '0 : div_q + 1'b1;
      prime_d = prime_q;
      if (tick && prime_q != PRIME_FULL) prime_d = prime_q + 1'b1;
      // Filt settles one cycle after the last priming tick and FiltPrev one
      // cycle later, so arming waits two cycles to hide reset-time levels.
      settle_d = (prime_q == PRIME_FULL);
      armed_d  = settle_q;
      out_d    = out_q;
      dir_d    = dir_q;
      edge_d   = edge_q;
      both_d   = both_q;
      inten_d  = inten_q;
      if (we) begin
         case (Addr)
            GPIO_DATA:  out_d   = DataWr;
            GPIO_DIR:   dir_d   = DataWr;
            GPIO_SET:   out_d   = out_q | DataWr;
            GPIO_CLR:   out_d   = out_q & ~DataWr;
            GPIO_EDGE:  edge_d  = DataWr;
            GPIO_BOTH:  both_d  = DataWr;
            GPIO_INTEN: inten_d = DataWr;
            default:    ;
         endcase
      end
      clr    = IntClr | ((we && Addr == GPIO_STAT) ? DataWr : '0);
      stat_d = (stat_q & ~clr) | ev;
      irq_d  = |(stat_q & inten_q);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         div_q    <= '0;
         prime_q  <= '0;
         settle_q <= 1'b0;
         armed_q  <= 1'b0;
         out_q    <= '0;
         dir_q    <= '0;
         edge_q   <= '0;
         both_q   <= '0;
         inten_q  <= '0;
         stat_q   <= '0;
         irq_q    <= 1'b0;
      end else begin
         div_q    <= div_d;
         prime_q  <= prime_d;
         settle_q <= settle_d;
         armed_q  <= armed_d;
         out_q    <= out_d;
         dir_q    <= dir_d;
         edge_q   <= edge_d;
         both_q   <= both_d;
         inten_q  <= inten_d;
         stat_q   <= stat_d;
         irq_q    <= irq_d;
      end
   end

   always_comb begin
      DataRd = '0;
      if (En) begin
         case (Addr)
            GPIO_DATA:  DataRd = sync;
            GPIO_DIR:   DataRd = dir_q;
            GPIO_SET:   DataRd = out_q;
            GPIO_CLR:   DataRd = out_q;
            GPIO_EDGE:  DataRd = edge_q;
            GPIO_BOTH:  DataRd = both_q;
            GPIO_INTEN: DataRd = inten_q;
            GPIO_STAT:  DataRd = stat_q;
            default:    DataRd = '0;
         endcase
      end
   end

   assign IntStatus = stat_q;
   assign Irq       = irq_q;

endmodule

// File: tb/tb_gpio_int_multi.sv
// Scenario bench for gpio_int_multi: directed feature tasks plus randomized
// pin/register traffic checked against a level-change interrupt model.
module tb_gpio_int_multi;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [2:0]  Addr = 3'd0;
   logic [15:0] DataRd;
   logic [15:0] DataWr = 16'h0;
   logic        En = 1'b0, Rd = 1'b0, Wr = 1'b0;
   wire  [15:0] port_w;
   logic [15:0] IntStatus;
   logic [15:0] IntClr = 16'h0;
   logic        Irq;
   logic [15:0] ext_en = 16'hFFFF, ext_val = 16'hA5A5;
   int          n_vec = 0, n_err = 0;

   always #5 Clk = ~Clk;

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_ext
         assign port_w[gi] = ext_en[gi] ? ext_val[gi] : 1'bz;
      end
   endgenerate

   gpio_int_multi #(.W(16), .DIV(4), .FILT_LEN(2)) dut (
      .Clk(Clk), .Reset(Reset), .Addr(Addr), .DataRd(DataRd), .DataWr(DataWr),
      .En(En), .Rd(Rd), .Wr(Wr), .Port(port_w), .IntStatus(IntStatus),
      .IntClr(IntClr), .Irq(Irq)
   );

   // Bus drivers: called on a falling edge, return on a falling edge.
   task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
      Addr = a; DataWr = d; En = 1'b1; Wr = 1'b1;
      @(negedge Clk);
      En = 1'b0; Wr = 1'b0;
   endtask

   task automatic bus_rd(input logic [2:0] a, output logic [15:0] d);
      Addr = a; En = 1'b1; Rd = 1'b1;
      #1 d = DataRd;
      @(negedge Clk);
      En = 1'b0; Rd = 1'b0;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic test_reset;
      logic [15:0] d;
      Reset = 1'b1; cyc(3); Reset = 1'b0; cyc(40);
      n_vec++; if (IntStatus !== 16'h0) begin n_err++; $display("FAIL reset_status got %h exp 0000", IntStatus); end
      n_vec++; if (Irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b exp 0", Irq); end
      n_vec++; if (port_w !== 16'hA5A5) begin n_err++; $display("FAIL reset_pins_undriven got %h exp a5a5", port_w); end
      bus_rd(3'd0, d);
      n_vec++; if (d !== 16'hA5A5) begin n_err++; $display("FAIL reset_data_read got %h exp a5a5", d); end
      for (int a = 1; a < 8; a++) begin
         bus_rd(3'(a), d);
         n_vec++; if (d !== 16'h0) begin n_err++; $display("FAIL reset_reg%0d got %h exp 0000", a, d); end
      end
      $display("reset: checked pins, status, irq and register file");
   endtask

   task automatic test_output;
      logic [15:0] d;
      ext_en = 16'hFF00;
      bus_wr(3'd1, 16'h00FF);
      bus_wr(3'd0, 16'h0F0F);
      bus_wr(3'd2, 16'h0030);
      bus_wr(3'd3, 16'h0001);
      n_vec++; if (port_w[7:0] !== 8'h3E) begin n_err++; $display("FAIL out_pins got %h exp 3e", port_w[7:0]); end
      bus_rd(3'd2, d);
      n_vec++; if (d !== 16'h0F3E) begin n_err++; $display("FAIL out_read_set got %h exp 0f3e", d); end
      bus_rd(3'd1, d);
      n_vec++; if (d !== 16'h00FF) begin n_err++; $display("FAIL out_read_dir got %h exp 00ff", d); end
      cyc(3);
      bus_rd(3'd0, d);
      n_vec++; if (d !== 16'hA53E) begin n_err++; $display("FAIL out_read_data got %h exp a53e", d); end
      Addr = 3'd2; #1;
      n_vec++; if (DataRd !== 16'h0) begin n_err++; $display("FAIL out_no_en_read got %h exp 0000", DataRd); end
      $display("output: pins[7:0]=%h", port_w[7:0]);
      bus_wr(3'd0, 16'h0000);
      bus_wr(3'd1, 16'h0000);
      ext_val = 16'h0000; ext_en = 16'hFFFF;
      cyc(30);
      bus_wr(3'd7, 16'hFFFF); cyc(2);
      n_vec++; if (IntStatus !== 16'h0) begin n_err++; $display("FAIL out_cleanup_status got %h exp 0000", IntStatus); end
   endtask

   task automatic wait_irq(input string nm);
      int c = 0;
      while (Irq !== 1'b1 && c < 16) begin @(negedge Clk); c++; end
      n_vec++; if (Irq !== 1'b1) begin n_err++; $display("FAIL %s irq got %b exp 1 within 16", nm, Irq); end
      $display("%s: irq after %0d cycles", nm, c);
   endtask

   task automatic test_edges;
      bus_wr(3'd6, 16'hFFFF);
      bus_wr(3'd4, 16'h0002);
      bus_wr(3'd5, 16'h0004);
      ext_val = 16'h0007;
      wait_irq("edge_rise");
      cyc(20);
      n_vec++; if (IntStatus !== 16'h0005) begin n_err++; $display("FAIL edge_rise_status got %h exp 0005", IntStatus); end
      bus_wr(3'd7, 16'h0005); cyc(2);
      n_vec++; if (Irq !== 1'b0) begin n_err++; $display("FAIL edge_irq_drop got %b exp 0", Irq); end
      ext_val = 16'h0000;
      wait_irq("edge_fall");
      cyc(20);
      n_vec++; if (IntStatus !== 16'h0006) begin n_err++; $display("FAIL edge_fall_status got %h exp 0006", IntStatus); end
      bus_wr(3'd7, 16'hFFFF); cyc(2);
   endtask

   task automatic test_glitch;
      ext_val[3] = 1'b1; cyc(3); ext_val[3] = 1'b0; cyc(24);
      n_vec++; if (IntStatus !== 16'h0000) begin n_err++; $display("FAIL glitch_short got %h exp 0000", IntStatus); end
      ext_val[3] = 1'b1; cyc(12); ext_val[3] = 1'b0; cyc(24);
      n_vec++; if (IntStatus !== 16'h0008) begin n_err++; $display("FAIL glitch_long got %h exp 0008", IntStatus); end
      $display("glitch: status=%h", IntStatus);
   endtask

   task automatic test_clear_mask;
      logic seen = 1'b0;
      ext_val = 16'h0007; cyc(20);
      ext_val = 16'h0000; cyc(20);
      n_vec++; if (IntStatus !== 16'h000F) begin n_err++; $display("FAIL clr_setup got %h exp 000f", IntStatus); end
      bus_wr(3'd7, 16'h0001);
      n_vec++; if (IntStatus !== 16'h000E) begin n_err++; $display("FAIL clr_w1c got %h exp 000e", IntStatus); end
      IntClr = 16'h0002; cyc(1); IntClr = 16'h0000;
      n_vec++; if (IntStatus !== 16'h000C) begin n_err++; $display("FAIL clr_hw got %h exp 000c", IntStatus); end
      bus_wr(3'd6, 16'h0000); cyc(1);
      n_vec++; if (Irq !== 1'b0) begin n_err++; $display("FAIL clr_mask_irq got %b exp 0", Irq); end
      n_vec++; if (IntStatus !== 16'h000C) begin n_err++; $display("FAIL clr_mask_status got %h exp 000c", IntStatus); end
      bus_wr(3'd6, 16'hFFFF);
      IntClr = 16'h0001; ext_val[0] = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge Clk);
         if (IntStatus[0] === 1'b1) seen = 1'b1;
      end
      IntClr = 16'h0000;
      n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL clr_set_wins got %b exp 1", seen); end
      n_vec++; if (IntStatus !== 16'h000C) begin n_err++; $display("FAIL clr_after_level got %h exp 000c", IntStatus); end
      ext_val[0] = 1'b0; cyc(20);
      $display("clear_mask: status=%h", IntStatus);
   endtask

   task automatic test_reset_mid;
      logic [15:0] d;
      bus_wr(3'd0, 16'h0000);
      ext_en = 16'h0000;
      bus_wr(3'd1, 16'hFFFF);
      bus_wr(3'd5, 16'hFFFF);
      cyc(20);
      bus_wr(3'd7, 16'hFFFF);
      bus_wr(3'd0, 16'hFFFF);
      cyc(20);
      n_vec++; if (IntStatus !== 16'hFFFF) begin n_err++; $display("FAIL mid_setup got %h exp ffff", IntStatus); end
      n_vec++; if (Irq !== 1'b1) begin n_err++; $display("FAIL mid_setup_irq got %b exp 1", Irq); end
      Reset = 1'b1; ext_val = 16'hFFFF; ext_en = 16'hFFFF;
      @(negedge Clk); Reset = 1'b0;
      n_vec++; if (IntStatus !== 16'h0) begin n_err++; $display("FAIL mid_status got %h exp 0000", IntStatus); end
      n_vec++; if (Irq !== 1'b0) begin n_err++; $display("FAIL mid_irq got %b exp 0", Irq); end
      for (int a = 1; a < 7; a++) begin
         bus_rd(3'(a), d);
         n_vec++; if (d !== 16'h0) begin n_err++; $display("FAIL mid_reg%0d got %h exp 0000", a, d); end
      end
      cyc(40);
      n_vec++; if (IntStatus !== 16'h0) begin n_err++; $display("FAIL mid_priming got %h exp 0000", IntStatus); end
      $display("reset_mid: status after priming=%h", IntStatus);
   endtask

   // Reference model: pins only ever change after being held long enough for
   // the filter, so every level change is one edge event on that pin.
   task automatic test_random;
      logic [15:0] lvl = 16'hFFFF, st = 16'h0, out_m = 16'h0;
      logic [15:0] edge_m, both_m, inten_m, nv, mask, d;
      for (int r = 0; r < 8; r++) begin
         edge_m = 16'($urandom); both_m = 16'($urandom); inten_m = 16'($urandom);
         bus_wr(3'd4, edge_m); bus_wr(3'd5, both_m); bus_wr(3'd6, inten_m); cyc(2);
         bus_rd(3'd4, d);
         n_vec++; if (d !== edge_m) begin n_err++; $display("FAIL rnd%0d_edge got %h exp %h", r, d, edge_m); end
         bus_rd(3'd5, d);
         n_vec++; if (d !== both_m) begin n_err++; $display("FAIL rnd%0d_both got %h exp %h", r, d, both_m); end
         bus_rd(3'd6, d);
         n_vec++; if (d !== inten_m) begin n_err++; $display("FAIL rnd%0d_inten got %h exp %h", r, d, inten_m); end
         n_vec++; if (IntStatus !== st) begin n_err++; $display("FAIL rnd%0d_cfg_keeps got %h exp %h", r, IntStatus, st); end
         nv = 16'($urandom);
         ext_val = nv; cyc(24);
         for (int i = 0; i < 16; i++) begin
            if (!lvl[i] && nv[i] && (both_m[i] || !edge_m[i])) st[i] = 1'b1;
            if (lvl[i] && !nv[i] && (both_m[i] || edge_m[i]))  st[i] = 1'b1;
         end
         lvl = nv;
         n_vec++; if (IntStatus !== st) begin n_err++; $display("FAIL rnd%0d_status got %h exp %h", r, IntStatus, st); end
         n_vec++; if (Irq !== ((st & inten_m) != 16'h0)) begin n_err++; $display("FAIL rnd%0d_irq got %b exp %b", r, Irq, (st & inten_m) != 16'h0); end
         bus_rd(3'd0, d);
         n_vec++; if (d !== lvl) begin n_err++; $display("FAIL rnd%0d_data got %h exp %h", r, d, lvl); end
         mask = 16'($urandom);
         bus_wr(3'd7, mask); cyc(2);
         st = st & ~mask;
         n_vec++; if (IntStatus !== st) begin n_err++; $display("FAIL rnd%0d_w1c got %h exp %h", r, IntStatus, st); end
         n_vec++; if (Irq !== ((st & inten_m) != 16'h0)) begin n_err++; $display("FAIL rnd%0d_w1c_irq got %b exp %b", r, Irq, (st & inten_m) != 16'h0); end
         d = 16'($urandom);
         case (r % 3)
            0: begin bus_wr(3'd0, d); out_m = d; end
            1: begin bus_wr(3'd2, d); out_m = out_m | d; end
            default: begin bus_wr(3'd3, d); out_m = out_m & ~d; end
         endcase
         bus_rd(3'd3, d);
         n_vec++; if (d !== out_m) begin n_err++; $display("FAIL rnd%0d_outreg got %h exp %h", r, d, out_m); end
         $display("random %0d: pins=%h status=%h irq=%b", r, lvl, IntStatus, Irq);
      end
   endtask

   initial begin
      test_reset;
      test_output;
      test_edges;
      test_glitch;
      test_clear_mask;
      test_reset_mid;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
